// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit_pkg                                                |
// | Purpose  : Shared definitions for the instruction fetch stage: FSM state |
// |            encoding, default reset PC / HALT opcode and PC arithmetic.   |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package fetch_unit_pkg;

    // Fetch sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    localparam logic [15:0] c_reset_pc_def = 16'h0000;
    localparam logic [4:0]  c_halt_op_def  = 5'b00000;

    // Next sequential instruction address; wraps modulo 2^16.
    function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit_pc_reg                                             |
// | Purpose  : 16-bit program counter with redirect / increment mux.         |
// |            Redirect has priority over increment. Bit 0 is always zero.   |
// | Ports    : clk, rst_n       clock, asynchronous active-low reset         |
// |            redir_i         load redir_pc_i (bit 0 forced low)            |
// |            redir_pc_i      redirect target                               |
// |            inc_i           advance PC by 2 (mod 2^16)                    |
// |            pc_o            current PC                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_unit_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = c_reset_pc_def
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_i,
    input  logic [15:0] redir_pc_i,
    input  logic        inc_i,
    output logic [15:0] pc_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redir_i) begin
            pc_d = redir_pc_i & 16'hFFFE;
        end else if (inc_i) begin
            pc_d = pc_plus2(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC & 16'hFFFE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction fetch stage. Issues one 16-bit read at a time,    |
// |            holds the fetched word until the decoder accepts it, follows  |
// |            branch/jump redirects and stops after delivering HALT.        |
// | Ports    : clk, rst_n                 clock, async active-low reset      |
// |            imem_req/addr/ready       read request handshake             |
// |            imem_rvalid/rdata         read response (1 per request)      |
// |            redirect_vld/pc           taken branch/jump                  |
// |            dec_ready                 decoder accepts instr              |
// |            instr_vld/instr/opcode    output register to decoder         |
// |            pc_out/pc_inc             address of instr and +2            |
// |            halted                    HALT delivered, fetch stopped      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = c_reset_pc_def,
    parameter logic [4:0]  HALT_OP  = c_halt_op_def
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_vld,
    input  logic [15:0] redirect_pc,
    input  logic        dec_ready,
    output logic        instr_vld,
    output logic [15:0] instr,
    output logic [4:0]  opcode,
    output logic [15:0] pc_out,
    output logic [15:0] pc_inc,
    output logic        halted
);

    fetch_state_e state_q, state_d;

    logic        squash_q,    squash_d;
    logic        instr_vld_q, instr_vld_d;
    logic [15:0] instr_q,     instr_d;
    logic [15:0] pc_out_q,    pc_out_d;
    logic        halted_q,    halted_d;

    logic [15:0] pc;
    logic        pc_redir;
    logic        pc_inc_en;
    logic        xfer;
    logic        req_ok;

    // A redirect kills the held instruction, so it can never transfer in
    // the same cycle.
    assign xfer   = instr_vld_q & dec_ready & ~redirect_vld;
    // Only request when the output register is free (or frees this cycle),
    // so a returning word always has somewhere to land.
    assign req_ok = ~redirect_vld & (~instr_vld_q | xfer);

    assign imem_req  = (state_q == S_REQ) & req_ok;
    assign imem_addr = pc;

    fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .redir_i    (pc_redir),
        .redir_pc_i (redirect_pc),
        .inc_i      (pc_inc_en),
        .pc_o       (pc)
    );

    always_comb begin
        state_d     = state_q;
        squash_d    = squash_q;
        instr_vld_d = instr_vld_q & ~(xfer | redirect_vld);
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        halted_d    = halted_q;
        pc_redir    = 1'b0;
        pc_inc_en   = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (redirect_vld) begin
                    pc_redir = 1'b1;
                end else if (imem_req && imem_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_vld) begin
                        // Response belongs to the old path: drop it and
                        // restart from the target; nothing left in flight.
                        pc_redir = 1'b1;
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        instr_d     = imem_rdata;
                        pc_out_d    = pc;
                        instr_vld_d = 1'b1;
                        pc_inc_en   = 1'b1;
                        state_d     = (imem_rdata[15:11] == HALT_OP) ? S_HALT : S_REQ;
                    end
                end else if (redirect_vld) begin
                    // Read still outstanding: remember to discard its data.
                    pc_redir = 1'b1;
                    squash_d = 1'b1;
                end
            end

            S_HALT: begin
                if (!halted_q) begin
                    if (redirect_vld) begin
                        pc_redir = 1'b1;
                        state_d  = S_REQ;
                    end else if (xfer) begin
                        halted_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_q    <= 1'b0;
            instr_vld_q <= 1'b0;
            instr_q     <= 16'h0000;
            pc_out_q    <= 16'h0000;
            halted_q    <= 1'b0;
        end else begin
            squash_q    <= squash_d;
            instr_vld_q <= instr_vld_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            halted_q    <= halted_d;
        end
    end

    assign instr_vld = instr_vld_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[15:11];
    assign pc_out    = pc_out_q;
    assign pc_inc    = pc_plus2(pc_out_q);
    assign halted    = halted_q;

endmodule

`default_nettype wire
